// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, count type and helpers for the RAM-backed FIFO
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 10;

  // Occupancy count for the default depth; one extra bit so DEPTH itself fits
  typedef logic [DEFAULT_ADDR_WIDTH:0] count_t;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple-dual-port RAM with synchronous read, block-RAM inferable
module fifo_ram_sdp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Write port: contents are never reset so the array maps onto a RAM block
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output that only changes on an enabled read
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ram_fifo_sync.sv
// rtl/ram_fifo_sync.sv - single-clock FIFO over an inferred SDP RAM with registered flags
module ram_fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int REG_RD     = 0,
  parameter int AF_THRESH  = 2**ADDR_WIDTH - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Flush,
  input  logic                  Push,
  input  logic [DATA_WIDTH-1:0] Push_Data,
  input  logic                  Pop,
  output logic [DATA_WIDTH-1:0] Pop_Data,
  output logic                  Pop_Valid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_Full,
  output logic                  Almost_Empty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  if (!(AE_THRESH < AF_THRESH && AF_THRESH <= DEPTH)) begin : g_bad_thresh
    $error("ram_fifo_sync: need AE_THRESH < AF_THRESH <= DEPTH");
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 36) begin : g_bad_width
    $error("ram_fifo_sync: DATA_WIDTH must be 1..36");
  end
  if (REG_RD != 0 && REG_RD != 1) begin : g_bad_reg_rd
    $error("ram_fifo_sync: REG_RD must be 0 or 1");
  end
  if (clog2(DEPTH + 1) != ADDR_WIDTH + 1) begin : g_bad_count_w
    $error("ram_fifo_sync: Count width cannot hold DEPTH");
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count_nxt;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Acceptance uses the registered flags; flush overrides any request
  always_comb begin
    push_ok   = Push & ~Full & ~Flush;
    pop_ok    = Pop & ~Empty & ~Flush;
    count_nxt = Count + (ADDR_WIDTH+1)'(push_ok) - (ADDR_WIDTH+1)'(pop_ok);
  end

  // Pointers, occupancy, flags and pulses; flags come from the next count so they stay registered
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Count        <= '0;
      Empty        <= 1'b1;
      Full         <= 1'b0;
      Almost_Full  <= 1'b0;
      Almost_Empty <= 1'b1;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else if (Flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Count        <= '0;
      Empty        <= 1'b1;
      Full         <= 1'b0;
      Almost_Full  <= 1'b0;
      Almost_Empty <= 1'b1;
      Overflow     <= 1'b0;
      Underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      Count        <= count_nxt;
      Empty        <= (count_nxt == '0);
      Full         <= (count_nxt == DEPTH_C);
      Almost_Full  <= (count_nxt >= AF_C);
      Almost_Empty <= (count_nxt <= AE_C);
      Overflow     <= Push & Full;
      Underflow    <= Pop & Empty;
      rd_valid     <= pop_ok;
    end
  end

  fifo_ram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (Clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (Push_Data),
    .re    (pop_ok),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (REG_RD == 0) begin : g_lat1
    logic rd_seen;

    // The RAM output register has no reset, so mask it until the first real read
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)      rd_seen <= 1'b0;
      else if (pop_ok) rd_seen <= 1'b1;
    end

    assign Pop_Data  = rd_seen ? ram_rdata : '0;
    assign Pop_Valid = rd_valid;
  end else begin : g_lat2
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Extra output stage; flush discards a word still in flight but keeps the held data
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (Flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_valid;
        if (rd_valid) data_q <= ram_rdata;
      end
    end

    assign Pop_Data  = data_q;
    assign Pop_Valid = valid_q;
  end

endmodule
